// File: rtl/bcd_counter_8d.sv
// bcd_counter_8d
// -----------------------------------------------------------------------------
// Eight-digit BCD up/down counter with a built-in prescaler. The prescaler
// counts enabled clk cycles. Every DIV of them it produces one internal step,
// and each step moves the count by one in the selected direction. Everything
// runs on clk, and the prescaler acts only as a clock enable.
//
// Ports
//   clk       in   1  system clock, all state updates on the rising edge
//   rst       in   1  asynchronous active-high reset
//   en        in   1  count enable; 0 freezes the prescaler and the digits
//   up        in   1  direction (1 = increment); only its value on a step edge matters
//   load      in   1  one-cycle synchronous load strobe (wins over a step)
//   load_val  in  32  eight BCD nibbles to load, digit 0 = [3:0]
//   Hexs      out 32  current count, eight BCD nibbles, registered
//   tick      out  1  one-cycle pulse in the cycle Hexs shows a stepped value
//   Rc        out  1  one-cycle pulse in the cycle Hexs shows a wrapped value
//
// Handshake: none. The outputs are plain registered state. tick and Rc are
// qualifiers that are valid in the same cycle as the Hexs value they describe.
// -----------------------------------------------------------------------------
module bcd_counter_8d #(
    parameter int unsigned DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] Hexs,
    output logic        tick,
    output logic        Rc
);

    localparam logic [31:0] DIV_M1 = DIV - 32'd1;

    logic [31:0] presc_q, presc_d;
    logic [31:0] hexs_q, hexs_d;
    logic        tick_q, tick_d;
    logic        rc_q, rc_d;
    logic        presc_end;
    logic        wrap;

    // Any nibble above 9 is forced to 9, so Hexs never holds a non-BCD digit.
    function automatic logic [31:0] bcd_clamp(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < 8; i++) begin
            if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Ripple increment: a 9 rolls to 0 and passes the carry to the next digit.
    function automatic logic [31:0] bcd_inc(input logic [31:0] v);
        logic [31:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple decrement: a 0 rolls to 9 and borrows from the next digit.
    function automatic logic [31:0] bcd_dec(input logic [31:0] v);
        logic [31:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (b) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign presc_end = (presc_q == DIV_M1);
    assign wrap      = up ? (hexs_q == 32'h9999_9999) : (hexs_q == 32'h0000_0000);

    always_comb begin
        presc_d = presc_q;
        hexs_d  = hexs_q;
        tick_d  = 1'b0;
        rc_d    = 1'b0;
        if (load) begin
            // A load on a step edge suppresses the step and restarts the prescaler.
            hexs_d  = bcd_clamp(load_val);
            presc_d = 32'd0;
        end else if (en) begin
            if (presc_end) begin
                presc_d = 32'd0;
                hexs_d  = up ? bcd_inc(hexs_q) : bcd_dec(hexs_q);
                tick_d  = 1'b1;
                rc_d    = wrap;
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= 32'd0;
            hexs_q  <= 32'd0;
            tick_q  <= 1'b0;
            rc_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            hexs_q  <= hexs_d;
            tick_q  <= tick_d;
            rc_q    <= rc_d;
        end
    end

    assign Hexs = hexs_q;
    assign tick = tick_q;
    assign Rc   = rc_q;

endmodule

// File: tb/tb_bcd_counter_8d.sv
// Bench for bcd_counter_8d. It runs two instances, with DIV=1 and DIV=4, on
// shared stimulus. A decimal-integer reference model computes the expected
// outputs of each instance, and a monitor checks them after every clock edge.
module tb_bcd_counter_8d;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [31:0] load_val = 32'd0;

    always #5 clk = ~clk;

    logic [31:0] hexs1, hexs4;
    logic        tick1, tick4, rc1, rc4;

    bcd_counter_8d #(.DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .Hexs(hexs1), .tick(tick1), .Rc(rc1)
    );

    bcd_counter_8d #(.DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .Hexs(hexs4), .tick(tick4), .Rc(rc4)
    );

    // ---------------- scoreboard state ----------------
    logic [33:0] exp1_q[$];
    logic [33:0] exp4_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: the count is a plain decimal integer 0..99999999.
    int unsigned m_cnt[2];
    int unsigned m_pre[2];
    int unsigned m_div[2];

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned p;
        r = 32'd0;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int unsigned load_dec(input logic [31:0] lv);
        int unsigned s, p, d;
        s = 0;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            d = 32'(lv[i*4 +: 4]);
            if (d > 9) d = 9;
            s = s + d * p;
            p = p * 10;
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: Hexs=%h tick=%b Rc=%b, expected Hexs=%h tick=%b Rc=%b",
                     name, $time, act[33:2], act[1], act[0], exp[33:2], exp[1], exp[0]);
        end
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of inputs at the falling edge and pushes, for each
    // instance, the outputs expected after the following rising edge.
    task automatic cycle(input logic r, input logic e, input logic u,
                         input logic l, input logic [31:0] lv);
        logic t, w;
        @(negedge clk);
        rst = r; en = e; up = u; load = l; load_val = lv;
        for (int k = 0; k < 2; k++) begin
            t = 1'b0;
            w = 1'b0;
            if (r) begin
                m_cnt[k] = 0;
                m_pre[k] = 0;
            end else if (l) begin
                m_cnt[k] = load_dec(lv);
                m_pre[k] = 0;
            end else if (e) begin
                if (m_pre[k] == m_div[k] - 1) begin
                    m_pre[k] = 0;
                    t = 1'b1;
                    if (u) begin
                        w = (m_cnt[k] == 99_999_999);
                        m_cnt[k] = (m_cnt[k] + 1) % 100_000_000;
                    end else begin
                        w = (m_cnt[k] == 0);
                        m_cnt[k] = (m_cnt[k] + 99_999_999) % 100_000_000;
                    end
                end else begin
                    m_pre[k] = m_pre[k] + 1;
                end
            end
            if (k == 0) exp1_q.push_back({to_bcd(m_cnt[k]), t, w});
            else        exp4_q.push_back({to_bcd(m_cnt[k]), t, w});
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (exp1_q.size() > 0) check("dut1", {hexs1, tick1, rc1}, exp1_q.pop_front());
        if (exp4_q.size() > 0) check("dut4", {hexs4, tick4, rc4}, exp4_q.pop_front());
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] lv;
        m_div[0] = 1;
        m_div[1] = 4;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_pre[0] = 0; m_pre[1] = 0;

        // Reset held three cycles with en=1, then free counting.
        repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        repeat (6) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Up count with carry.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0099);
        repeat (4) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Up wrap.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h9999_9999);
        repeat (5) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Down wrap and borrow.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1000);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

        // Enable gating 1,1,0,0,1,1 after a load, then clamp with en=0.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0050);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_ABC3);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

        // Load on the DIV=4 step edge, then watch the prescaler restart.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h8765_4321);
        repeat (5) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Asynchronous reset between edges clears the outputs at once.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_dut1", {hexs1, tick1, rc1}, 34'd0);
        check("async_rst_dut4", {hexs4, tick4, rc4}, 34'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        repeat (4) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 4))
                0:       lv = 32'h9999_9999;
                1:       lv = 32'h0000_0000;
                2:       lv = 32'h9999_9997;
                3:       lv = 32'h0000_0002;
                default: lv = $urandom;
            endcase
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0, lv);
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp1_q.size() + exp4_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp1_q.size() + exp4_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
